// File: rtl/wb_regfile_pkg.sv
// cpu_defs: definitions shared by the writeback stage and the control unit.
//   DATA_W   default register/data width
//   REG_RA   jal link register index
//   REG_ZERO hard-wired zero register index
//   wbsel_e  writeback source selection encoding
package cpu_defs;

  localparam int DATA_W = 32;

  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wbsel_e;

  // jal dominates the load select
  function automatic wbsel_e wbSelect(input logic jal, input logic memtoreg);
    if (jal)           return WB_LINK;
    else if (memtoreg) return WB_MEM;
    else               return WB_ALU;
  endfunction

endpackage

// File: rtl/wb_regfile_wb_sel.sv
// wb_sel: combinational writeback mux and effective destination/enable.
//   regwriteW, memtoregW, jalW   control from MEM/WB
//   ALUoutW, MemoutW, pc_4W      candidate writeback values
//   dstregW                      decoded destination register
//   wdataW                       selected writeback value
//   wrDestW                      effective destination (31 on jal)
//   wrEnW                        effective write enable (regwrite | jal)
module wb_sel
  import cpu_defs::*;
#(
  parameter int DATA_W = cpu_defs::DATA_W
) (
  input  logic              regwriteW,
  input  logic              memtoregW,
  input  logic              jalW,
  input  logic [DATA_W-1:0] ALUoutW,
  input  logic [DATA_W-1:0] MemoutW,
  input  logic [DATA_W-1:0] pc_4W,
  input  logic [4:0]        dstregW,
  output logic [DATA_W-1:0] wdataW,
  output logic [4:0]        wrDestW,
  output logic              wrEnW
);

  wbsel_e sel;

  always_comb begin
    sel = wbSelect(jalW, memtoregW);
    unique case (sel)
      WB_LINK: wdataW = pc_4W;
      WB_MEM:  wdataW = MemoutW;
      default: wdataW = ALUoutW;
    endcase
  end

  always_comb begin
    wrDestW = jalW ? REG_RA : dstregW;
    wrEnW   = regwriteW | jalW;
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and 32 x DATA_W register file.
//   clk, rst            pipeline clock, synchronous active-high reset
//   regwriteW..dstregW  MEM/WB pipeline register fields
//   rsD, rtD            decode-stage read addresses
//   rdata1D, rdata2D    combinational read data with write-through bypass
//   wdataW              selected writeback value
//   trace_*W            registered record of the previous cycle's commit
//   commit_cnt          committed writes since reset (wraps)
module wb_regfile
  import cpu_defs::*;
#(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwriteW,
  input  logic              memtoregW,
  input  logic              jalW,
  input  logic [DATA_W-1:0] ALUoutW,
  input  logic [DATA_W-1:0] MemoutW,
  input  logic [DATA_W-1:0] pc_4W,
  input  logic [4:0]        dstregW,
  input  logic [4:0]        rsD,
  input  logic [4:0]        rtD,
  output logic [DATA_W-1:0] rdata1D,
  output logic [DATA_W-1:0] rdata2D,
  output logic [DATA_W-1:0] wdataW,
  output logic              trace_validW,
  output logic [4:0]        trace_regW,
  output logic [DATA_W-1:0] trace_dataW,
  output logic [CNT_W-1:0]  commit_cnt
);

  logic [4:0]        wrDest;
  logic              wrEn;
  logic              commit;
  logic              bypassOk;
  logic [DATA_W-1:0] regs [0:31];

  wb_sel #(.DATA_W(DATA_W)) uSel (
    .regwriteW (regwriteW),
    .memtoregW (memtoregW),
    .jalW      (jalW),
    .ALUoutW   (ALUoutW),
    .MemoutW   (MemoutW),
    .pc_4W     (pc_4W),
    .dstregW   (dstregW),
    .wdataW    (wdataW),
    .wrDestW   (wrDest),
    .wrEnW     (wrEn)
  );

  assign commit   = wrEn && (wrDest != REG_ZERO);
  // A commit in a reset cycle is dropped, so it must not be forwarded either
  assign bypassOk = commit && !rst;

  // Entry 0 is only ever cleared; reads of address 0 are forced to 0 anyway
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      commit_cnt   <= '0;
      trace_validW <= 1'b0;
      trace_regW   <= '0;
      trace_dataW  <= '0;
    end else begin
      trace_validW <= commit;
      if (commit) begin
        regs[wrDest] <= wdataW;
        commit_cnt   <= commit_cnt + 1'b1;
        trace_regW   <= wrDest;
        trace_dataW  <= wdataW;
      end
    end
  end

  always_comb begin
    if (rsD == REG_ZERO)                 rdata1D = '0;
    else if (bypassOk && rsD == wrDest)  rdata1D = wdataW;
    else                                 rdata1D = regs[rsD];
  end

  always_comb begin
    if (rtD == REG_ZERO)                 rdata2D = '0;
    else if (bypassOk && rtD == wrDest)  rdata2D = wdataW;
    else                                 rdata2D = regs[rtD];
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile. Stimulus is applied 1 time unit after each
// posedge and the expected outputs for that cycle are queued; a monitor pops
// and compares them at the following negedge. The counter is built 4 bits
// wide so that wrap-around is reachable in a few cycles.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int CW = 4;

  typedef enum int {S_RD1, S_RD2, S_WDATA, S_TVALID, S_TREG, S_TDATA, S_CNT} sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } chk_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          regwriteW, memtoregW, jalW;
  logic [DW-1:0] ALUoutW, MemoutW, pc_4W;
  logic [4:0]    dstregW, rsD, rtD;
  logic [DW-1:0] rdata1D, rdata2D, wdataW, trace_dataW;
  logic          trace_validW;
  logic [4:0]    trace_regW;
  logic [CW-1:0] commit_cnt;

  chk_t chkQ[$];
  int   nVec = 0;
  int   nMis = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .regwriteW    (regwriteW),
    .memtoregW    (memtoregW),
    .jalW         (jalW),
    .ALUoutW      (ALUoutW),
    .MemoutW      (MemoutW),
    .pc_4W        (pc_4W),
    .dstregW      (dstregW),
    .rsD          (rsD),
    .rtD          (rtD),
    .rdata1D      (rdata1D),
    .rdata2D      (rdata2D),
    .wdataW       (wdataW),
    .trace_validW (trace_validW),
    .trace_regW   (trace_regW),
    .trace_dataW  (trace_dataW),
    .commit_cnt   (commit_cnt)
  );

  // Monitor: compare every expectation queued for the current cycle
  always @(negedge clk) begin
    chk_t c;
    logic [31:0] act;
    while (chkQ.size() > 0) begin
      c = chkQ.pop_front();
      case (c.sig)
        S_RD1:    act = rdata1D;
        S_RD2:    act = rdata2D;
        S_WDATA:  act = wdataW;
        S_TVALID: act = {31'd0, trace_validW};
        S_TREG:   act = {27'd0, trace_regW};
        S_TDATA:  act = trace_dataW;
        default:  act = {{(32-CW){1'b0}}, commit_cnt};
      endcase
      nVec++;
      if (act !== c.exp) begin
        nMis++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  task automatic expect_(input string name, input sig_e sig, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    chkQ.push_back(c);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic mtr, input logic jal,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc, input logic [4:0] dst,
                       input logic [4:0] rs, input logic [4:0] rt);
    regwriteW = rw;  memtoregW = mtr; jalW = jal;
    ALUoutW   = alu; MemoutW   = mem; pc_4W = pc;
    dstregW   = dst; rsD       = rs;  rtD   = rt;
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 0, 0, 32'h1234, 0, 0, 5'd5, 5'd5, 5'd0);
    cyc();
    // Reset cycle: bypass suppressed, state cleared
    expect_("rst_rd1", S_RD1, 32'h0);
    expect_("rst_cnt", S_CNT, 32'h0);
    expect_("rst_tvalid", S_TVALID, 32'h0);
    cyc();
    rst = 1'b0;
    drive(0, 0, 0, 32'h1234, 0, 0, 5'd5, 5'd5, 5'd0);
    expect_("post_rst_rd1", S_RD1, 32'h0);
    expect_("post_rst_cnt", S_CNT, 32'h0);
    expect_("post_rst_tvalid", S_TVALID, 32'h0);
    cyc();

    // ALU write with same-cycle bypass
    drive(1, 0, 0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd8, 5'd8, 5'd0);
    expect_("alu_bypass", S_RD1, 32'hDEADBEEF);
    expect_("alu_rd2_zero", S_RD2, 32'h0);
    expect_("alu_wdata", S_WDATA, 32'hDEADBEEF);
    cyc();
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd8, 5'd0);
    expect_("alu_stored", S_RD1, 32'hDEADBEEF);
    expect_("alu_tvalid", S_TVALID, 32'h1);
    expect_("alu_treg", S_TREG, 32'd8);
    expect_("alu_tdata", S_TDATA, 32'hDEADBEEF);
    expect_("alu_cnt", S_CNT, 32'd1);
    cyc();

    // Load select
    drive(1, 1, 0, 32'h1111, 32'hCAFE0001, 32'h0, 5'd9, 5'd9, 5'd0);
    expect_("mem_wdata", S_WDATA, 32'hCAFE0001);
    expect_("mem_bypass", S_RD1, 32'hCAFE0001);
    cyc();

    // jal: link forced into r31 regardless of regwrite/dstreg
    drive(0, 0, 1, 32'h0, 32'h0, 32'h00400008, 5'd4, 5'd31, 5'd4);
    expect_("jal_wdata", S_WDATA, 32'h00400008);
    expect_("jal_bypass31", S_RD1, 32'h00400008);
    expect_("jal_r4_nobypass", S_RD2, 32'h0);
    expect_("mem_cnt", S_CNT, 32'd2);
    expect_("mem_treg", S_TREG, 32'd9);
    expect_("mem_tdata", S_TDATA, 32'hCAFE0001);
    cyc();
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd31, 5'd9);
    expect_("jal_r31", S_RD1, 32'h00400008);
    expect_("mem_r9", S_RD2, 32'hCAFE0001);
    expect_("jal_cnt", S_CNT, 32'd3);
    expect_("jal_treg", S_TREG, 32'd31);
    cyc();

    // Write to r0 is discarded
    drive(1, 0, 0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    expect_("r0_rd1_same", S_RD1, 32'h0);
    expect_("r0_rd2_same", S_RD2, 32'h0);
    cyc();
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4);
    expect_("r0_rd1_next", S_RD1, 32'h0);
    expect_("r4_unchanged", S_RD2, 32'h0);
    expect_("r0_cnt", S_CNT, 32'd3);
    expect_("r0_tvalid", S_TVALID, 32'h0);
    expect_("r0_treg_hold", S_TREG, 32'd31);
    expect_("r0_tdata_hold", S_TDATA, 32'h00400008);
    cyc();

    // Dual port on the same register, then independent addresses
    drive(1, 0, 0, 32'h55, 32'h0, 32'h0, 5'd8, 5'd8, 5'd8);
    expect_("dual_rd1", S_RD1, 32'h55);
    expect_("dual_rd2", S_RD2, 32'h55);
    cyc();
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd8, 5'd9);
    expect_("indep_rd1", S_RD1, 32'h55);
    expect_("indep_rd2", S_RD2, 32'hCAFE0001);
    expect_("dual_cnt", S_CNT, 32'd4);
    cyc();

    // Eleven more commits take the 4-bit counter to all-ones
    for (int k = 0; k < 11; k++) begin
      drive(1, 0, 0, 32'h100 + k, 32'h0, 32'h0, 5'(10 + k), 5'(10 + k), 5'd0);
      expect_("fill_bypass", S_RD1, 32'h100 + k);
      cyc();
    end
    drive(1, 0, 0, 32'h200, 32'h0, 32'h0, 5'd21, 5'd0, 5'd0);
    expect_("cnt_allones", S_CNT, 32'hF);
    cyc();
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd15, 5'd21);
    expect_("cnt_wrap", S_CNT, 32'h0);
    expect_("fill_r15", S_RD1, 32'h105);
    expect_("fill_r21", S_RD2, 32'h200);
    cyc();

    // Reset beats a same-cycle commit
    rst = 1'b1;
    drive(1, 0, 0, 32'h333, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0);
    expect_("rstpri_nobypass", S_RD1, 32'h0);
    cyc();
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd8);
    expect_("rstpri_r3", S_RD1, 32'h0);
    expect_("rstpri_r8_lost", S_RD2, 32'h0);
    expect_("rstpri_cnt", S_CNT, 32'h0);
    expect_("rstpri_tvalid", S_TVALID, 32'h0);
    expect_("rstpri_treg", S_TREG, 32'h0);
    expect_("rstpri_tdata", S_TDATA, 32'h0);
    cyc();

    // First commit after reset counts as 1
    drive(1, 0, 0, 32'h77, 32'h0, 32'h0, 5'd3, 5'd0, 5'd0);
    cyc();
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0);
    expect_("first_cnt", S_CNT, 32'd1);
    expect_("first_r3", S_RD1, 32'h77);
    cyc();

    // Let the monitor drain, bounded
    for (int w = 0; w < 10 && chkQ.size() > 0; w++) @(posedge clk);
    if (chkQ.size() > 0) begin
      nMis++;
      $display("FAIL drain: %0d checks pending, expected 0", chkQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
